// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the NoC ejection endpoint.
//   - Flit header field layout: dest X sits at the flit LSBs, dest Y directly above it.
//   - get_dest_x / get_dest_y: extract the destination fields from a flit (zero-extended).
//   - DROP_CNT_W: width of the misroute drop counter.
package noc_pkg;

    localparam int unsigned DROP_CNT_W       = 16;
    // Widest flit the field helpers accept; callers zero-extend narrower flits.
    localparam int unsigned MAX_FLIT_W       = 256;
    // Widest coordinate field the helpers return.
    localparam int unsigned DEST_FIELD_MAX_W = 16;
    // dest X starts at bit 0; dest Y starts at bit x_w (depends on the X width).
    localparam int unsigned DEST_X_LSB       = 0;

    function automatic logic [DEST_FIELD_MAX_W-1:0] get_dest_x(
        input logic [MAX_FLIT_W-1:0] flit,
        input int unsigned           x_w
    );
        logic [DEST_FIELD_MAX_W-1:0] f;
        f = '0;
        for (int unsigned i = 0; i < DEST_FIELD_MAX_W; i++) begin
            if (i < x_w) begin
                f[i] = flit[DEST_X_LSB + i];
            end
        end
        return f;
    endfunction

    function automatic logic [DEST_FIELD_MAX_W-1:0] get_dest_y(
        input logic [MAX_FLIT_W-1:0] flit,
        input int unsigned           x_w,
        input int unsigned           y_w
    );
        logic [DEST_FIELD_MAX_W-1:0] f;
        f = '0;
        for (int unsigned i = 0; i < DEST_FIELD_MAX_W; i++) begin
            if (i < y_w) begin
                f[i] = flit[DEST_X_LSB + x_w + i];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: first-word-fall-through synchronous FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write wr_data (ignored when full)
//   pop        : advance read pointer (ignored when empty)
//   wr_data    : write data
//   rd_data    : head of queue, valid whenever !empty
//   count      : current occupancy
//   full       : registered, computed from the next-state count (no comb path from push/pop)
//   empty      : occupancy is zero
module noc_sync_fifo #(
    parameter int unsigned D_W   = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [D_W-1:0]             wr_data,
    output logic [D_W-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("noc_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [D_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = (count_q == '0);

endmodule

// File: rtl/noc_eject_port.sv
// noc_eject_port: ejection endpoint of a torus router port.
// Accepts single-flit packets over a valid/backpressure link, buffers them in a FWFT FIFO
// and presents them to the local client on a valid/ready interface.
//   clk, rst  : clock, synchronous active-high reset
//   i_v, i_d  : flit valid/data from router; transfer when i_v && !i_b
//   i_b       : backpressure to router; registered FIFO-full flag
//   c_v, c_d  : flit valid/data to client; pop when c_v && c_r
//   c_r       : client ready
//   drop_cnt  : saturating count of discarded misrouted flits
//   err       : sticky misroute flag
// Build option NOC_EJECT_ADDR_CHECK_EN: when defined, flits whose dest X/Y differ from
// MY_X/MY_Y are accepted on the link but discarded and counted. When undefined every
// transferred flit is buffered and drop_cnt/err are tied to zero.
module noc_eject_port
    import noc_pkg::*;
#(
    parameter int unsigned D_W   = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned X_W   = 4,
    parameter int unsigned Y_W   = 4,
    parameter int unsigned MY_X  = 0,
    parameter int unsigned MY_Y  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_v,
    input  logic [D_W-1:0]        i_d,
    output logic                  i_b,
    output logic                  c_v,
    output logic [D_W-1:0]        c_d,
    input  logic                  c_r,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  err
);

    if (X_W + Y_W > D_W || X_W > DEST_FIELD_MAX_W || Y_W > DEST_FIELD_MAX_W
        || D_W > MAX_FLIT_W) begin : g_field_check
        $error("noc_eject_port: destination fields do not fit the flit");
    end
    if (MY_X >= (1 << X_W) || MY_Y >= (1 << Y_W)) begin : g_coord_check
        $error("noc_eject_port: MY_X/MY_Y out of range for X_W/Y_W");
    end

    logic                       accept;
    logic                       addr_match;
    logic                       push;
    logic                       pop;
    logic                       fifo_empty;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       unused_fifo_count;

    // i_b is the registered full flag, so accept has no path from c_r.
    assign accept = i_v && !i_b;

`ifdef NOC_EJECT_ADDR_CHECK_EN
    logic [MAX_FLIT_W-1:0]       flit_ext;
    logic [DROP_CNT_W-1:0]       drop_cnt_q;
    logic                        err_q;

    assign flit_ext   = MAX_FLIT_W'(i_d);
    assign addr_match = (get_dest_x(flit_ext, X_W) == DEST_FIELD_MAX_W'(MY_X))
                     && (get_dest_y(flit_ext, X_W, Y_W) == DEST_FIELD_MAX_W'(MY_Y));

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (accept && !addr_match) begin
            if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end
            err_q <= 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign err      = err_q;
`else
    assign addr_match = 1'b1;
    assign drop_cnt   = '0;
    assign err        = 1'b0;
`endif

    // Misrouted flits complete the link handshake but are never written.
    assign push = accept && addr_match;
    assign pop  = c_v && c_r;

    noc_sync_fifo #(
        .D_W   (D_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (i_d),
        .rd_data (c_d),
        .count   (fifo_count),
        .full    (i_b),
        .empty   (fifo_empty)
    );

    // Occupancy is exported by the FIFO for debug; c_v uses the empty flag.
    assign unused_fifo_count = ^fifo_count;
    assign c_v               = !fifo_empty;

endmodule

// File: tb/tb_noc_eject_port.sv
module tb_noc_eject_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_v;
    logic [31:0] i_d;
    logic        i_b;
    logic        c_v;
    logic [31:0] c_d;
    logic        c_r;
    logic [15:0] drop_cnt;
    logic        err;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_pops = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    noc_eject_port #(
        .D_W   (32),
        .DEPTH (4),
        .X_W   (4),
        .Y_W   (4),
        .MY_X  (1),
        .MY_Y  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_v      (i_v),
        .i_d      (i_d),
        .i_b      (i_b),
        .c_v      (c_v),
        .c_d      (c_d),
        .c_r      (c_r),
        .drop_cnt (drop_cnt),
        .err      (err)
    );

    // Flit addressed to this node (X=1, Y=2) carrying payload p.
    function automatic logic [31:0] mk(input logic [7:0] p);
        return {16'h0, p, 8'h21};
    endfunction

    // Misrouted flit (X=3, Y=2).
    function automatic logic [31:0] bad(input logic [7:0] p);
        return {16'h0, p, 8'h23};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One clock cycle: drive, record accepted flits in the model, advance past the edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        logic keep;
        i_v = v;
        i_d = d;
        c_r = r;
        @(negedge clk);
        keep = 1'b1;
`ifdef NOC_EJECT_ADDR_CHECK_EN
        keep = (d[3:0] == 4'd1) && (d[7:4] == 4'd2);
`endif
        if (v && !i_b && !rst && keep) begin
            exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every client pop is compared against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && c_v && c_r) begin
                n_pops++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pop: got %h expected none", c_d);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (c_d !== e) begin
                        n_bad++;
                        $display("FAIL c_d: got %h expected %h", c_d, e);
                    end
                end
            end
        end
    end

    initial begin
        int p0;
        logic ib_seen;
        rst = 1'b1;
        i_v = 1'b0;
        i_d = '0;
        c_r = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("reset_c_v", 32'(c_v), 32'd0);
        check("reset_i_b", 32'(i_b), 32'd0);
        check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Fill: i_b rises one cycle after the 4th accept.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, mk(8'hA0 + 8'(i)), 1'b0);
            check($sformatf("fill_i_b_%0d", i), 32'(i_b), (i == 3) ? 32'd1 : 32'd0);
        end
        check("fill_c_v", 32'(c_v), 32'd1);

        // Backpressure hold: B0 presented while full is not accepted.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, mk(8'hB0), 1'b0);
            check($sformatf("hold_i_b_%0d", i), 32'(i_b), 32'd1);
        end
        cyc(1'b1, mk(8'hB0), 1'b1);
        check("first_pop_i_b", 32'(i_b), 32'd0);
        cyc(1'b1, mk(8'hB0), 1'b1);
        check("push_pop_i_b", 32'(i_b), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        check("drain1_c_v", 32'(c_v), 32'd0);
        check("drain1_left", 32'(exp_q.size()), 32'd0);

        // Streaming: 100 flits back-to-back with the client always ready.
        ib_seen = 1'b0;
        p0 = n_pops;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, mk(8'(i)), 1'b1);
            if (i == 0) check("stream_latency_c_v", 32'(c_v), 32'd1);
            ib_seen = ib_seen | i_b;
        end
        check("stream_i_b_low", 32'(ib_seen), 32'd0);
        cyc(1'b0, '0, 1'b1);
        check("stream_pops", 32'(n_pops - p0), 32'd100);
        check("stream_c_v_end", 32'(c_v), 32'd0);

        // Simultaneous push/pop holding occupancy at 2.
        cyc(1'b1, mk(8'hC0), 1'b0);
        cyc(1'b1, mk(8'hC1), 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, mk(8'hC2 + 8'(i)), 1'b1);
        check("pp_i_b", 32'(i_b), 32'd0);
        p0 = n_pops;
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        check("pp_remaining", 32'(n_pops - p0), 32'd2);

        // Reset mid-stream with the FIFO full: old flits must vanish.
        for (int i = 0; i < 4; i++) cyc(1'b1, mk(8'hD0 + 8'(i)), 1'b0);
        rst = 1'b1;
        exp_q.delete();
        cyc(1'b0, '0, 1'b0);
        rst = 1'b0;
        check("midrst_c_v", 32'(c_v), 32'd0);
        check("midrst_i_b", 32'(i_b), 32'd0);
        cyc(1'b1, mk(8'hDA), 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("midrst_c_v_end", 32'(c_v), 32'd0);

        // Address check: (1,2), (3,2), (1,2).
        p0 = n_pops;
        cyc(1'b1, mk(8'hE0), 1'b0);
        cyc(1'b1, bad(8'hE1), 1'b0);
        cyc(1'b1, mk(8'hE2), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
`ifdef NOC_EJECT_ADDR_CHECK_EN
        check("addr_pops", 32'(n_pops - p0), 32'd2);
        check("addr_drop_cnt", 32'(drop_cnt), 32'd1);
        check("addr_err", 32'(err), 32'd1);
        for (int i = 0; i < 65533; i++) cyc(1'b1, bad(8'hEE), 1'b1);
        check("sat_drop_fffe", 32'(drop_cnt), 32'h0000FFFE);
        cyc(1'b1, bad(8'hEE), 1'b1);
        check("sat_drop_ffff", 32'(drop_cnt), 32'h0000FFFF);
        cyc(1'b1, bad(8'hEE), 1'b1);
        cyc(1'b1, bad(8'hEE), 1'b1);
        check("sat_drop_hold", 32'(drop_cnt), 32'h0000FFFF);
        check("sat_err", 32'(err), 32'd1);
        check("sat_c_v", 32'(c_v), 32'd0);
`else
        check("addr_pops", 32'(n_pops - p0), 32'd3);
        check("addr_drop_cnt", 32'(drop_cnt), 32'd0);
        check("addr_err", 32'(err), 32'd0);
`endif
        check("final_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
